tx_frame_ctrl: RTL and testbench
================================

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 Parameter: DATA_BITS, default 8, data bits per frame; frame = 1 start + DATA_BITS + 1 stop = 10 bits, matching tx_timer bit-count rollover of 10.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 tx_valid  input  1  upstream byte offered.
REQ-005 tx_data  input  DATA_BITS  byte to send, LSB transmitted first.
REQ-006 tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready at a rising edge.
REQ-007 shift_strobe  input  1  one-cycle pulse from tx_timer at end of each bit period (27 clocks).
REQ-008 bit_count  input  4  tx_timer count of completed bit periods since clear.
REQ-009 clear_timer  output  1  synchronous clear to tx_timer.
REQ-010 disable_timer  output  1  holds tx_timer idle when high.
REQ-011 serial_out  output  1  line output, idle level 1.
REQ-012 tx_busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after stop bit completes.

Function
REQ-014 One-entry holding register plus 10-bit shift register; tx_ready = holding empty (registered flag, no combinational path from tx_valid).
REQ-015 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE: disable_timer=1, clear_timer=0, serial_out=1; holding full -> LOAD next edge.
REQ-017 LOAD (exactly 1 cycle): clear_timer=1, disable_timer=1, serial_out=1; shift register <= {1'b1, holding, 1'b0}; holding marked empty; -> SHIFT.
REQ-018 SHIFT: disable_timer=0, clear_timer=0, serial_out = shift_reg[0]; on shift_strobe shift right, fill 1.
REQ-019 SHIFT exit: shift_strobe && bit_count >= 9 -> DONE (bit_count > 9 treated as done, no hang).
REQ-020 DONE (1 cycle): frame_done=1, disable_timer=1, serial_out=1; holding full -> LOAD, else -> IDLE.
REQ-021 Next-state decisions in IDLE/DONE use registered holding flag; byte accepted in same cycle takes effect next cycle.
REQ-022 Each bit, start bit included, drives serial_out for exactly 27 clocks; serial_out changes on edge following shift_strobe.
REQ-023 Back-to-back frames: stop bit 27 clocks, then DONE+LOAD give exactly 2 extra high cycles before next start bit.
REQ-024 Holding register loads while SHIFT/DONE/IDLE whenever empty; tx_data must not be sampled when tx_ready=0; offered byte never dropped or duplicated.
REQ-025 shift_strobe and bit_count ignored outside SHIFT.
REQ-026 frame_done never asserted except in DONE; clear_timer never asserted except in LOAD.

Reset
REQ-027 n_rst low, asynchronously: state IDLE, holding empty, shift register all 1s, tx_ready=1, tx_busy=0, serial_out=1, disable_timer=1, clear_timer=0, frame_done=0.
REQ-028 Reset mid-frame aborts frame, discards holding byte; no frame_done issued.
REQ-029 First byte after reset release: tx_valid accepted on first rising edge with n_rst high.

Verification (bench instantiates tx_timer as the strobe source)
REQ-030 Reset: assert n_rst=0 mid-cycle -> all outputs at REQ-027 values before next edge.
REQ-031 Single byte 0xA5 -> serial_out 0,1,0,1,0,0,1,0,1,1, each 27 clocks; one frame_done pulse; IDLE, tx_busy=0 afterwards.
REQ-032 Back-to-back: 0x00 then 0xFF, second accepted during first SHIFT -> stop bit of first 27 clocks high + 2 cycles, then start bit of 0xFF; two frame_done pulses exactly 272 clocks apart.
REQ-033 Backpressure: three bytes 0x11, 0x22, 0x33 offered continuously -> tx_ready=0 while holding full, all three transmitted in order, none lost.
REQ-034 Reset during bit 4 of 0x5A with 0xC3 held -> serial_out=1 immediately, no frame_done, 0xC3 not transmitted after release.
REQ-035 Forced shift_strobe pulses in IDLE with bit_count=9 -> no state change, serial_out stays 1, no frame_done.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// Serial frame transmitter: one-entry holding register feeding a start/data/stop
// shift register, paced by strobes from an external bit timer.
module tx_frame_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 shift_strobe,
  input  logic [3:0]           bit_count,
  output logic                 clear_timer,
  output logic                 disable_timer,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  // state | meaning
  // IDLE  | line high, timer held, waiting for a held byte
  // LOAD  | one cycle: clear timer, move holding byte into shift register
  // SHIFT | timer running, one frame bit per strobe
  // DONE  | one cycle: frame_done pulse, then reload or go idle
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t                 state;
  logic                   hold_full;
  logic [DATA_BITS-1:0]   hold_data;
  logic [FRAME_BITS-1:0]  shift_reg;

  assign tx_ready   = ~hold_full;
  // Shift register idles at all ones, so the line is high outside SHIFT.
  assign serial_out = shift_reg[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (state == LOAD) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      shift_reg     <= '1;
      tx_busy       <= 1'b0;
      disable_timer <= 1'b1;
      clear_timer   <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      clear_timer <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            state         <= LOAD;
            tx_busy       <= 1'b1;
            clear_timer   <= 1'b1;
            disable_timer <= 1'b1;
          end
        end
        LOAD: begin
          state         <= SHIFT;
          shift_reg     <= {1'b1, hold_data, 1'b0};
          disable_timer <= 1'b0;
        end
        SHIFT: begin
          if (shift_strobe) begin
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            // Counts past the last bit also end the frame so a glitch cannot hang us.
            if (bit_count >= LAST_BIT) begin
              state         <= DONE;
              frame_done    <= 1'b1;
              disable_timer <= 1'b1;
            end
          end
        end
        DONE: begin
          if (hold_full) begin
            state       <= LOAD;
            clear_timer <= 1'b1;
          end else begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          shift_reg     <= '1;
          tx_busy       <= 1'b0;
          disable_timer <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: behavioural bit timer, frame-timeline model,
// line receiver and directed scenarios with literal expectations.
module tb_tx_frame_ctrl;
  localparam int DB         = 8;
  localparam int BIT_CLKS   = 27;
  localparam int FRAME_CLKS = 2 + (DB + 2) * BIT_CLKS;  // LOAD + 10 bits + DONE = 272

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_ready, shift_strobe, clear_timer, disable_timer;
  logic          serial_out, tx_busy, frame_done;
  logic [3:0]    bit_count;

  tx_frame_ctrl #(.DATA_BITS(DB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .shift_strobe(shift_strobe), .bit_count(bit_count),
    .clear_timer(clear_timer), .disable_timer(disable_timer),
    .serial_out(serial_out), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0b want %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Bit timer: 27-clock periods, strobe on the last clock, bit count wraps at 10.
  int         t_cnt;
  logic [3:0] t_bc;
  logic       t_strobe;
  logic       force_en = 1'b0, force_strobe = 1'b0;
  logic [3:0] force_bc = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      t_cnt <= 0; t_bc <= '0;
    end else if (clear_timer) begin
      t_cnt <= 0; t_bc <= '0;
    end else if (disable_timer) begin
      t_cnt <= 0;
    end else if (t_cnt == BIT_CLKS - 1) begin
      t_cnt <= 0;
      t_bc  <= (t_bc == 4'd9) ? 4'd0 : t_bc + 4'd1;
    end else begin
      t_cnt <= t_cnt + 1;
    end
  end
  assign t_strobe     = !disable_timer && (t_cnt == BIT_CLKS - 1);
  assign shift_strobe = force_en ? force_strobe : t_strobe;
  assign bit_count    = force_en ? force_bc : t_bc;

  // Model: frame position p (0 idle, 1 load, 2..271 bits, 272 done) plus holding slot.
  int            m_p;
  logic          m_full;
  logic [DB-1:0] m_hold, m_byte;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_p <= 0; m_full <= 1'b0; m_hold <= '0; m_byte <= '1;
    end else begin
      if (m_p == 0) begin
        if (m_full) m_p <= 1;
      end else if (m_p == 1) begin
        m_p <= 2; m_byte <= m_hold;
      end else if (m_p < FRAME_CLKS) begin
        m_p <= m_p + 1;
      end else begin
        m_p <= m_full ? 1 : 0;
      end
      if (m_p == 1) m_full <= 1'b0;
      else if (tx_valid && !m_full) begin
        m_full <= 1'b1; m_hold <= tx_data;
      end
    end
  end

  function automatic logic exp_serial(input int p, input logic [DB-1:0] b);
    int k;
    if (p < 2 || p >= FRAME_CLKS) return 1'b1;
    k = (p - 2) / BIT_CLKS;
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    check("serial_out",    serial_out,    exp_serial(m_p, m_byte));
    check("tx_ready",      tx_ready,      !m_full);
    check("tx_busy",       tx_busy,       m_p != 0);
    check("clear_timer",   clear_timer,   m_p == 1);
    check("disable_timer", disable_timer, !(m_p >= 2 && m_p < FRAME_CLKS));
    check("frame_done",    frame_done,    m_p == FRAME_CLKS);
  end

  // Line receiver, edge log and frame_done log.
  logic          rx_act = 1'b0, rx_prev = 1'b1;
  int            rx_t;
  logic [DB-1:0] rx_sh;
  logic [DB-1:0] rx_q[$];
  int            edges[$];
  int            fd_q[$];

  always @(negedge clk) begin
    if (!n_rst) begin
      rx_act  = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (rx_act) begin
        rx_t++;
        if (rx_t % BIT_CLKS == BIT_CLKS / 2) begin
          if (rx_t / BIT_CLKS == 0) check("rx_start_bit", serial_out, 1'b0);
          else if (rx_t / BIT_CLKS <= DB) rx_sh[rx_t / BIT_CLKS - 1] = serial_out;
          else begin
            check("rx_stop_bit", serial_out, 1'b1);
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
          end
        end
      end else if (serial_out == 1'b0 && rx_prev == 1'b1) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
      if (serial_out !== rx_prev) edges.push_back(cyc);
      rx_prev = serial_out;
      if (frame_done) fd_q.push_back(cyc);
    end
  end

  int stall = 0;

  // Caller is at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [DB-1:0] d);
    int w = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && w < 1000) begin
      stall++;
      @(negedge clk);
      w++;
    end
    check("send_timeout", w < 1000, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i = 0;
    while ((rx_q.size() < n || tx_busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, i < budget, 1'b1);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    edges.delete();
    fd_q.delete();
  endtask

  int exp_a5[7] = '{27, 27, 27, 27, 54, 27, 27};
  int exp_b2b[3] = '{243, 29, 27};
  logic [DB-1:0] exp_bp[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_serial", serial_out, 1'b1);
    check("rst_ready",  tx_ready,   1'b1);
    check("rst_busy",   tx_busy,    1'b0);

    // Byte offered together with reset release is taken on the first edge.
    n_rst = 1'b1;
    send(8'hA5);
    check("first_accept", tx_ready, 1'b0);
    tx_valid = 1'b0;
    wait_frames(1, 1000, "a5_timeout");
    check_int("a5_frames", rx_q.size(), 1);
    if (rx_q.size() >= 1) check_int("a5_byte", int'(rx_q[0]), 8'hA5);
    check_int("a5_done_pulses", fd_q.size(), 1);
    check_int("a5_edges", edges.size(), 8);
    for (int i = 0; i < 7; i++)
      if (edges.size() > i + 1) check_int("a5_bit_len", edges[i+1] - edges[i], exp_a5[i]);
    check("a5_idle_busy", tx_busy, 1'b0);

    // Back-to-back: 0xFF lands in the holding slot during the first SHIFT.
    clear_logs();
    send(8'h00);
    send(8'hFF);
    tx_valid = 1'b0;
    wait_frames(2, 1500, "b2b_timeout");
    check_int("b2b_frames", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check_int("b2b_byte0", int'(rx_q[0]), 8'h00);
      check_int("b2b_byte1", int'(rx_q[1]), 8'hFF);
    end
    check_int("b2b_done_pulses", fd_q.size(), 2);
    if (fd_q.size() >= 2) check_int("b2b_done_spacing", fd_q[1] - fd_q[0], 272);
    check_int("b2b_edges", edges.size(), 4);
    for (int i = 0; i < 3; i++)
      if (edges.size() > i + 1) check_int("b2b_run_len", edges[i+1] - edges[i], exp_b2b[i]);

    // Backpressure: three bytes offered with no gaps.
    clear_logs();
    stall = 0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    tx_valid = 1'b0;
    check("bp_stalled", stall > 0, 1'b1);
    wait_frames(3, 2500, "bp_timeout");
    check_int("bp_frames", rx_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > i) check_int("bp_byte", int'(rx_q[i]), int'(exp_bp[i]));
    check_int("bp_done_pulses", fd_q.size(), 3);

    // Reset during bit 4 of 0x5A with 0xC3 held.
    clear_logs();
    send(8'h5A);
    send(8'hC3);
    tx_valid = 1'b0;
    begin
      int w = 0;
      while (edges.size() < 1 && w < 100) begin @(negedge clk); w++; end
      check("rst_mid_start_seen", w < 100, 1'b1);
    end
    repeat (4 * BIT_CLKS + 10) @(negedge clk);
    check("rst_mid_busy_before", tx_busy, 1'b1);
    check("rst_mid_held_before", tx_ready, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_serial",  serial_out,    1'b1);
    check("async_rst_ready",   tx_ready,      1'b1);
    check("async_rst_busy",    tx_busy,       1'b0);
    check("async_rst_disable", disable_timer, 1'b1);
    check("async_rst_clear",   clear_timer,   1'b0);
    check("async_rst_done",    frame_done,    1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (700) @(negedge clk);
    check_int("rst_mid_done_pulses", fd_q.size(), 0);
    check_int("rst_mid_frames", rx_q.size(), 0);
    check("rst_mid_idle", tx_busy, 1'b0);

    // Stray strobes in IDLE must be ignored.
    clear_logs();
    force_en = 1'b1;
    force_bc = 4'd9;
    for (int i = 0; i < 5; i++) begin
      force_strobe = 1'b1;
      @(negedge clk);
      check("force_serial", serial_out, 1'b1);
      force_strobe = 1'b0;
      @(negedge clk);
    end
    force_en = 1'b0;
    check("force_busy", tx_busy, 1'b0);
    check_int("force_done_pulses", fd_q.size(), 0);
    check_int("force_edges", edges.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d: got running want finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
